// File: rtl/lcd_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// lcd_ctrl_if - host valid/ready handshake into the LCD controller FIFO
// rev 1.0
//------------------------------------------------------------------------------
interface lcd_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_is_cmd;
  logic [7:0] in_data;

  modport master (output in_valid, output in_is_cmd, output in_data, input in_ready);
  modport slave  (input in_valid, input in_is_cmd, input in_data, output in_ready);
endinterface
`default_nettype wire

// File: rtl/lcd_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// lcd_ctrl - HD44780-class character LCD controller with init ROM and host FIFO
// rev 1.0
//------------------------------------------------------------------------------
module lcd_ctrl #(
  parameter int BUS_4BIT       = 0,
  parameter int POWERUP_CYCLES = 100,
  parameter int EN_CYCLES      = 4,
  parameter int CMD_CYCLES     = 50,
  parameter int LONG_CYCLES    = 2000,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  lcd_ctrl_if.slave  host,
  output logic       init_complete,
  output logic       busy,
  output logic       disp_e,
  output logic       disp_rw,
  output logic       disp_rs,
  output logic [7:0] disp_data
);

  localparam int MAX_A   = (POWERUP_CYCLES > EN_CYCLES) ? POWERUP_CYCLES : EN_CYCLES;
  localparam int MAX_B   = (CMD_CYCLES > LONG_CYCLES) ? CMD_CYCLES : LONG_CYCLES;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int ROM_LEN = (BUS_4BIT != 0) ? 8 : 4;
  localparam logic [AW:0] FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    IDLE     = 3'd1,
    SETUP    = 3'd2,
    PULSE    = 3'd3,
    HOLD     = 3'd4,
    WAIT     = 3'd5
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    rom_idx, rom_idx_nx;
  logic [7:0]    cur_byte, byte_nx;
  logic          cur_single, single_nx;
  logic          low_phase, low_nx;
  logic          rs_nx, init_nx;
  logic [7:0]    data_nx;
  logic          start, start_rs, start_single;
  logic [7:0]    start_byte;
  logic          long_wait;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic [8:0]    head;

  // Init ROM word is {single_nibble, byte}; single nibbles sit in the high half.
  function automatic logic [8:0] rom_entry(input logic [2:0] idx);
    logic [8:0] e;
    e = 9'h000;
    if (BUS_4BIT != 0) begin
      case (idx)
        3'd0, 3'd1, 3'd2: e = {1'b1, 8'h30};
        3'd3:             e = {1'b1, 8'h20};
        3'd4:             e = {1'b0, 8'h28};
        3'd5:             e = {1'b0, 8'h0C};
        3'd6:             e = {1'b0, 8'h06};
        default:          e = {1'b0, 8'h01};
      endcase
    end else begin
      case (idx)
        3'd0:    e = {1'b0, 8'h38};
        3'd1:    e = {1'b0, 8'h0C};
        3'd2:    e = {1'b0, 8'h06};
        default: e = {1'b0, 8'h01};
      endcase
    end
    return e;
  endfunction

  assign host.in_ready = (count != FIFO_FULL);
  assign push          = host.in_valid && host.in_ready;
  assign pop           = (state == IDLE) && init_complete && (count != '0);
  assign head          = mem[rd_ptr];
  assign busy          = (state != IDLE) || (count != '0);
  assign disp_e        = (state == PULSE);
  assign disp_rw       = 1'b0;
  assign long_wait     = !disp_rs && (cur_byte[7:2] == 6'd0) && (cur_byte != 8'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {host.in_is_cmd, host.in_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW + 1)'(1);
      else if (pop && !push) count <= count - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= PWR_WAIT;
      cnt           <= CW'(POWERUP_CYCLES - 1);
      rom_idx       <= '0;
      cur_byte      <= '0;
      cur_single    <= 1'b0;
      low_phase     <= 1'b0;
      disp_rs       <= 1'b0;
      disp_data     <= '0;
      init_complete <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      rom_idx       <= rom_idx_nx;
      cur_byte      <= byte_nx;
      cur_single    <= single_nx;
      low_phase     <= low_nx;
      disp_rs       <= rs_nx;
      disp_data     <= data_nx;
      init_complete <= init_nx;
    end
  end

  // Init writes reuse the transfer states; rom_idx selects the entry until init_complete.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    rom_idx_nx   = rom_idx;
    byte_nx      = cur_byte;
    single_nx    = cur_single;
    low_nx       = low_phase;
    rs_nx        = disp_rs;
    data_nx      = disp_data;
    init_nx      = init_complete;
    start        = 1'b0;
    start_rs     = 1'b0;
    start_single = 1'b0;
    start_byte   = 8'h00;
    case (state)
      PWR_WAIT: begin
        if (cnt == '0) begin
          start = 1'b1;
          {start_single, start_byte} = rom_entry(3'd0);
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      IDLE: begin
        if (pop) begin
          start      = 1'b1;
          start_rs   = !head[8];
          start_byte = head[7:0];
        end
      end
      SETUP: begin
        state_nx = PULSE;
        cnt_nx   = CW'(EN_CYCLES - 1);
      end
      PULSE: begin
        if (cnt == '0) state_nx = HOLD;
        else           cnt_nx   = cnt - CW'(1);
      end
      HOLD: begin
        if ((BUS_4BIT != 0) && !cur_single && !low_phase) begin
          low_nx   = 1'b1;
          data_nx  = {cur_byte[3:0], 4'h0};
          state_nx = SETUP;
        end else begin
          state_nx = WAIT;
          cnt_nx   = long_wait ? CW'(LONG_CYCLES - 1) : CW'(CMD_CYCLES - 1);
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CW'(1);
        end else if (init_complete) begin
          state_nx = IDLE;
        end else if (rom_idx == 3'(ROM_LEN - 1)) begin
          init_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          rom_idx_nx = rom_idx + 3'd1;
          start      = 1'b1;
          {start_single, start_byte} = rom_entry(rom_idx + 3'd1);
        end
      end
      default: state_nx = PWR_WAIT;
    endcase
    if (start) begin
      state_nx  = SETUP;
      byte_nx   = start_byte;
      single_nx = start_single;
      low_nx    = 1'b0;
      rs_nx     = start_rs;
      data_nx   = (BUS_4BIT != 0) ? {start_byte[7:4], 4'h0} : start_byte;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_lcd_ctrl - directed checks of lcd_ctrl in 8-bit and 4-bit bus modes
// rev 1.0
//------------------------------------------------------------------------------
module tb_lcd_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_ctrl_if h8();
  lcd_ctrl_if h4();

  logic       init8, busy8, e8, rw8, rs8;
  logic [7:0] d8;
  logic       init4, busy4, e4, rw4, rs4;
  logic [7:0] d4;

  lcd_ctrl #(.BUS_4BIT(0), .POWERUP_CYCLES(20), .EN_CYCLES(2), .CMD_CYCLES(5),
             .LONG_CYCLES(40), .FIFO_DEPTH(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .host(h8), .init_complete(init8), .busy(busy8),
    .disp_e(e8), .disp_rw(rw8), .disp_rs(rs8), .disp_data(d8));

  lcd_ctrl #(.BUS_4BIT(1), .POWERUP_CYCLES(20), .EN_CYCLES(2), .CMD_CYCLES(5),
             .LONG_CYCLES(40), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .host(h4), .init_complete(init4), .busy(busy4),
    .disp_e(e4), .disp_rw(rw4), .disp_rs(rs4), .disp_data(d4));

  typedef struct {
    int         rise;
    int         fall;
    int         width;
    logic       rs;
    logic [7:0] data;
    logic       stable;
  } pulse_t;

  pulse_t q8[$];
  pulse_t q4[$];
  pulse_t cur8, cur4;
  logic   prev8 = 1'b0, prev4 = 1'b0;
  int     cyc = 0;
  int     ic8 = -1, ic4 = -1;
  int     total = 0, bad = 0;

  logic [7:0] init8_exp [4]  = '{8'h38, 8'h0C, 8'h06, 8'h01};
  logic [3:0] nib4_exp  [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};

  // cyc = posedges since reset release; each completed E pulse is recorded.
  always @(posedge clk) begin
    if (!rst_n) cyc = 0;
    else        cyc = cyc + 1;
    #1;
    if (!rst_n) begin
      prev8 = 1'b0; prev4 = 1'b0; ic8 = -1; ic4 = -1;
    end else begin
      if (init8 && ic8 < 0) ic8 = cyc;
      if (init4 && ic4 < 0) ic4 = cyc;
      if (e8 && !prev8) begin
        cur8.rise = cyc; cur8.width = 1; cur8.rs = rs8; cur8.data = d8; cur8.stable = 1'b1;
      end else if (e8) begin
        cur8.width = cur8.width + 1;
        if (rs8 !== cur8.rs || d8 !== cur8.data) cur8.stable = 1'b0;
      end else if (prev8) begin
        cur8.fall = cyc; q8.push_back(cur8);
      end
      if (e4 && !prev4) begin
        cur4.rise = cyc; cur4.width = 1; cur4.rs = rs4; cur4.data = d4; cur4.stable = 1'b1;
      end else if (e4) begin
        cur4.width = cur4.width + 1;
        if (rs4 !== cur4.rs || d4 !== cur4.data) cur4.stable = 1'b0;
      end else if (prev4) begin
        cur4.fall = cyc; q4.push_back(cur4);
      end
      prev8 = e8;
      prev4 = e4;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    h8.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    q8.delete();
    q4.delete();
  endtask

  task automatic push8(input logic is_cmd, input logic [7:0] data, output int acc);
    logic r;
    h8.in_valid = 1'b1; h8.in_is_cmd = is_cmd; h8.in_data = data;
    acc = -1;
    for (int k = 0; k < 400 && acc < 0; k++) begin
      r = h8.in_ready;
      tick();
      if (r) acc = cyc;
    end
    h8.in_valid = 1'b0;
  endtask

  task automatic wait_idle8(output int fall_cyc);
    fall_cyc = -1;
    for (int k = 0; k < 400 && fall_cyc < 0; k++) begin
      tick();
      if (!busy8) fall_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total++; if (init8 !== 1'b0) begin bad++; $display("FAIL reset_init8: got %b want 0", init8); end
    total++; if (e8 !== 1'b0) begin bad++; $display("FAIL reset_e8: got %b want 0", e8); end
    total++; if (rw8 !== 1'b0) begin bad++; $display("FAIL reset_rw8: got %b want 0", rw8); end
    total++; if (rs8 !== 1'b0) begin bad++; $display("FAIL reset_rs8: got %b want 0", rs8); end
    total++; if (d8 !== 8'h00) begin bad++; $display("FAIL reset_data8: got %h want 00", d8); end
    total++; if (h8.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready8: got %b want 1", h8.in_ready); end
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL reset_busy8: got %b want 1", busy8); end
    total++; if ({init4, e4, rw4, rs4, d4} !== 12'h000) begin
      bad++; $display("FAIL reset_dut4: got %h want 000", {init4, e4, rw4, rs4, d4});
    end
    tick();
    rst_n = 1'b1;
    q8.delete();
    q4.delete();
  endtask

  task automatic test_init8();
    for (int k = 0; k < 400 && cyc < 150; k++) tick();
    total++; if (q8.size() !== 4) begin bad++; $display("FAIL init8_count: got %0d want 4", q8.size()); end
    for (int i = 0; i < 4; i++) begin
      if (q8.size() > i) begin
        total++;
        if (q8[i].data !== init8_exp[i] || q8[i].rs !== 1'b0 || q8[i].width !== 2 || q8[i].stable !== 1'b1) begin
          bad++;
          $display("FAIL init8_write%0d: got data=%h rs=%b width=%0d stable=%b want data=%h rs=0 width=2 stable=1",
                   i, q8[i].data, q8[i].rs, q8[i].width, q8[i].stable, init8_exp[i]);
        end
      end
    end
    if (q8.size() > 0) begin
      total++; if (q8[0].rise !== 21) begin bad++; $display("FAIL init8_first_rise: got %0d want 21", q8[0].rise); end
    end
    if (q8.size() > 3) begin
      total++; if (q8[3].fall !== 50) begin bad++; $display("FAIL init8_clear_hold: got %0d want 50", q8[3].fall); end
    end
    total++; if (ic8 !== 91) begin bad++; $display("FAIL init8_complete: got %0d want 91", ic8); end
  endtask

  task automatic test_init4();
    total++; if (q4.size() !== 12) begin bad++; $display("FAIL init4_count: got %0d want 12", q4.size()); end
    for (int i = 0; i < 12; i++) begin
      if (q4.size() > i) begin
        total++;
        if (q4[i].data !== {nib4_exp[i], 4'h0} || q4[i].rs !== 1'b0 || q4[i].width !== 2) begin
          bad++;
          $display("FAIL init4_nibble%0d: got data=%h rs=%b width=%0d want data=%h rs=0 width=2",
                   i, q4[i].data, q4[i].rs, q4[i].width, {nib4_exp[i], 4'h0});
        end
      end
    end
    if (q4.size() > 5) begin
      total++;
      if (q4[4].rise !== 57 || q4[5].rise !== 61) begin
        bad++; $display("FAIL init4_byte_timing: got %0d,%0d want 57,61", q4[4].rise, q4[5].rise);
      end
    end
    total++; if (ic4 !== 143) begin bad++; $display("FAIL init4_complete: got %0d want 143", ic4); end
  endtask

  task automatic test_single_char();
    int s, acc, fall;
    q8.delete();
    s = cyc;
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL char_idle_busy: got %b want 0", busy8); end
    push8(1'b0, 8'h41, acc);
    total++; if (acc !== s + 1) begin bad++; $display("FAIL char_accept: got %0d want %0d", acc, s + 1); end
    wait_idle8(fall);
    total++; if (fall !== acc + 10) begin bad++; $display("FAIL char_busy_fall: got %0d want %0d", fall, acc + 10); end
    total++; if (q8.size() !== 1) begin bad++; $display("FAIL char_count: got %0d want 1", q8.size()); end
    if (q8.size() > 0) begin
      total++;
      if (q8[0].data !== 8'h41 || q8[0].rs !== 1'b1 || q8[0].width !== 2 || q8[0].rise !== acc + 2) begin
        bad++;
        $display("FAIL char_pulse: got data=%h rs=%b width=%0d rise=%0d want data=41 rs=1 width=2 rise=%0d",
                 q8[0].data, q8[0].rs, q8[0].width, q8[0].rise, acc + 2);
      end
    end
  endtask

  task automatic test_cmd_gaps();
    int acc, fall;
    logic [8:0] exp [4];
    exp = '{{1'b0, 8'h02}, {1'b1, 8'h42}, {1'b0, 8'h80}, {1'b1, 8'h43}};
    q8.delete();
    push8(1'b1, 8'h02, acc);
    push8(1'b0, 8'h42, acc);
    push8(1'b1, 8'h80, acc);
    push8(1'b0, 8'h43, acc);
    wait_idle8(fall);
    total++; if (q8.size() !== 4) begin bad++; $display("FAIL gap_count: got %0d want 4", q8.size()); end
    for (int i = 0; i < 4; i++) begin
      if (q8.size() > i) begin
        total++;
        if ({q8[i].rs, q8[i].data} !== exp[i]) begin
          bad++; $display("FAIL gap_entry%0d: got %h want %h", i, {q8[i].rs, q8[i].data}, exp[i]);
        end
      end
    end
    if (q8.size() > 3) begin
      // wait cycles = rise - HOLD sample - (IDLE + SETUP + own edge)
      total++; if (q8[1].rise - q8[0].fall - 3 !== 40) begin
        bad++; $display("FAIL gap_home: got %0d want 40", q8[1].rise - q8[0].fall - 3);
      end
      total++; if (q8[2].rise - q8[1].fall - 3 !== 5) begin
        bad++; $display("FAIL gap_data: got %0d want 5", q8[2].rise - q8[1].fall - 3);
      end
      total++; if (q8[3].rise - q8[2].fall - 3 !== 5) begin
        bad++; $display("FAIL gap_cmd80: got %0d want 5", q8[3].rise - q8[2].fall - 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc [5];
    int fall;
    apply_reset();
    for (int i = 0; i < 4; i++) push8(1'b0, 8'h31 + 8'(i), acc[i]);
    total++; if (acc[0] !== 1 || acc[3] !== 4) begin
      bad++; $display("FAIL b2b_accept: got %0d,%0d want 1,4", acc[0], acc[3]);
    end
    total++; if (h8.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: got ready=%b want 0", h8.in_ready); end
    push8(1'b0, 8'h35, acc[4]);
    total++; if (acc[4] !== 93) begin bad++; $display("FAIL b2b_fifth_accept: got %0d want 93", acc[4]); end
    wait_idle8(fall);
    total++; if (q8.size() !== 9) begin bad++; $display("FAIL b2b_count: got %0d want 9", q8.size()); end
    for (int i = 0; i < 5; i++) begin
      if (q8.size() > i + 4) begin
        total++;
        if (q8[i + 4].data !== 8'h31 + 8'(i) || q8[i + 4].rs !== 1'b1 || q8[i + 4].rise !== 93 + 10 * i) begin
          bad++;
          $display("FAIL b2b_entry%0d: got data=%h rs=%b rise=%0d want data=%h rs=1 rise=%0d",
                   i, q8[i + 4].data, q8[i + 4].rs, q8[i + 4].rise, 8'h31 + 8'(i), 93 + 10 * i);
        end
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    int acc;
    apply_reset();
    for (int i = 0; i < 4; i++) push8(1'b0, 8'h50 + 8'(i), acc);
    for (int k = 0; k < 200 && cyc < 39; k++) tick();
    total++; if (e8 !== 1'b1 || d8 !== 8'h06) begin
      bad++; $display("FAIL abort_precond: got e=%b data=%h want e=1 data=06", e8, d8);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (e8 !== 1'b0) begin bad++; $display("FAIL abort_e_drop: got %b want 0", e8); end
    total++; if (d8 !== 8'h00 || init8 !== 1'b0 || h8.in_ready !== 1'b1) begin
      bad++; $display("FAIL abort_state: got data=%h init=%b ready=%b want 00 0 1", d8, init8, h8.in_ready);
    end
    tick();
    rst_n = 1'b1;
    q8.delete();
    q4.delete();
    for (int k = 0; k < 400 && cyc < 120; k++) tick();
    total++; if (q8.size() !== 4) begin bad++; $display("FAIL abort_restart_count: got %0d want 4", q8.size()); end
    if (q8.size() > 0) begin
      total++; if (q8[0].rise !== 21 || q8[0].data !== 8'h38) begin
        bad++; $display("FAIL abort_restart_first: got rise=%0d data=%h want 21 38", q8[0].rise, q8[0].data);
      end
    end
    total++; if (busy8 !== 1'b0 || ic8 !== 91) begin
      bad++; $display("FAIL abort_fifo_empty: got busy=%b init_cyc=%0d want 0 91", busy8, ic8);
    end
  endtask

  initial begin
    h8.in_valid = 1'b0; h8.in_is_cmd = 1'b0; h8.in_data = 8'h00;
    h4.in_valid = 1'b0; h4.in_is_cmd = 1'b0; h4.in_data = 8'h00;
    test_reset();
    test_init8();
    test_init4();
    test_single_char();
    test_cmd_gaps();
    test_back_to_back();
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
